cic_iq_sequencer: RTL and testbench
===================================

Name: cic_iq_sequencer

Overview:
- Controller for a pair of CIC decimators (I and Q channels, 2 integrator / 2 comb stages, 16-bit outputs).
- Generates the shared decimator input tick and drives the decimator reset.
- Flushes and settles the filters after enable or a rate change, then pairs I/Q output samples.
- Pairs pass through a 2-entry buffer to a valid/ready consumer (demodulator / sample streamer).

Parameters:
- FLUSH_CYCLES, 4, cycles cic_rstb is held low on entry to FLUSH.
- SETTLE_PAIRS, 2, paired outputs discarded after flush (comb delay-line fill).
- SKEW_MAX, 3, max cycles between I and Q ticks of the same pair.
- DIV_BITS, 8, width of tick divider config.

Ports:
- CLK  in  1  system clock.
- RSTb  in  1  asynchronous active-low reset.
- enable  in  1  run request.
- tick_div  in  DIV_BITS  input tick period minus one.
- cic_in_tick  out  1  one-cycle pulse to both decimators' in_tick.
- cic_rstb  out  1  active-low synchronous reset to both decimators.
- i_tick  in  1  I decimator out_tick.
- i_sample  in  16  I decimator x_out.
- q_tick  in  1  Q decimator out_tick.
- q_sample  in  16  Q decimator x_out.
- out_valid  out  1  pair available.
- out_ready  in  1  consumer accepts.
- out_i  out  16  I sample of head pair.
- out_q  out  16  Q sample of head pair.
- overrun  out  1  sticky: pair dropped because buffer full.
- sync_err  out  1  sticky: I/Q pairing failure.
- running  out  1  high in RUN state.

Behaviour:
- Reset (RSTb low, async): state IDLE; cic_in_tick 0, cic_rstb 0, out_valid 0, out_i/out_q 0, overrun 0, sync_err 0, running 0; buffer empty; divider count 0.
- States: IDLE -> FLUSH -> SETTLE -> RUN.
- IDLE: cic_rstb 0, no ticks. enable=1 -> FLUSH; tick_div is latched into div_reg on this transition.
- FLUSH: cic_rstb 0 for exactly FLUSH_CYCLES cycles, then SETTLE with cic_rstb 1; divider count cleared.
- SETTLE: ticks run; the first SETTLE_PAIRS completed pairs are discarded (not buffered); then RUN.
- RUN: running=1; completed pairs are pushed into the buffer.
- In any non-IDLE state, enable=0 -> IDLE next cycle: buffer cleared, out_valid 0, pairing latches cleared. Sticky flags are held.
- In SETTLE/RUN, tick_div != div_reg -> FLUSH: tick_div is relatched, the buffer is cleared, and sticky flags are held.
- Divider (SETTLE/RUN only): count increments each cycle. When count==div_reg, cic_in_tick=1 for that cycle and count wraps to 0. Tick period is div_reg+1; div_reg=0 gives a tick every cycle.
- Pairing:
  - i_tick latches i_sample and sets i_have; q_tick likewise sets q_have.
  - A pair completes in the cycle both haves are set, or both ticks arrive together. The pair is used next cycle and both haves clear.
  - If a tick arrives while its own have is already set: sync_err=1, the new sample replaces the old, and the skew timer restarts.
  - Skew timer starts when exactly one have is set. If it exceeds SKEW_MAX cycles: sync_err=1, the have clears, and the sample is dropped.
- Buffer: 2 entries, FIFO order. out_i/out_q/out_valid are registered from the head entry. Transfer occurs when out_valid & out_ready.
  - Push and pop in the same cycle are both permitted when full.
  - Push when full with no pop: the new pair is dropped and overrun=1.
- Latency: pair completes at cycle t; out_valid is high at t+2 when the buffer was empty.
- Sticky flags clear only on RSTb.

Test Plan:
- Reset then enable=1, tick_div=3 -> cic_rstb low 4 cycles; cic_in_tick pulses every 4 cycles; first 2 pairs discarded; running=1; 3rd pair (I=0x0123, Q=0xFEDC) at out_valid with out_i=0x0123, out_q=0xFEDC.
- RUN, I tick at t and Q tick at t+3 -> pair emitted, sync_err 0. Q tick at t+5 instead -> sync_err=1, I sample dropped, no out_valid.
- RUN, out_ready=0, 3 pairs delivered -> first 2 held in order, 3rd dropped, overrun=1; out_ready=1 -> pairs 1 then 2 pop, out_valid falls.
- RUN, change tick_div 3->0 -> FLUSH (cic_rstb low 4 cycles), buffer empty, then cic_in_tick every cycle, 2 pairs discarded.
- Two I ticks before a Q tick -> sync_err=1, emitted pair uses the second I sample.
- RSTb asserted mid-RUN with out_valid=1 -> all outputs immediately at reset values, including overrun/sync_err cleared.

Source files
------------

// File: rtl/cic_iq_sequencer.sv
// cic_iq_sequencer
//   Controller for a pair of CIC decimators (I and Q). It generates the shared
//   decimator input tick and drives the decimator reset. After enable or a
//   rate change it flushes and settles the filters, then pairs I/Q output
//   samples into a 2-entry buffer drained by a valid/ready consumer.
//
// Ports
//   CLK, RSTb            clock, asynchronous active-low reset
//   enable               run request
//   tick_div             input tick period minus one
//   cic_in_tick          one-cycle pulse to both decimators' in_tick
//   cic_rstb             active-low synchronous reset to both decimators
//   i_tick / i_sample    I decimator out_tick / x_out
//   q_tick / q_sample    Q decimator out_tick / x_out
//   out_valid/out_ready  head-of-buffer handshake
//   out_i / out_q        head pair
//   overrun              sticky: pair dropped because buffer full
//   sync_err             sticky: I/Q pairing failure
//   running              high in RUN state
module cic_iq_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned SETTLE_PAIRS = 2,
  parameter int unsigned SKEW_MAX     = 3,
  parameter int unsigned DIV_BITS     = 8
) (
  input  logic                CLK,
  input  logic                RSTb,
  input  logic                enable,
  input  logic [DIV_BITS-1:0] tick_div,
  output logic                cic_in_tick,
  output logic                cic_rstb,
  input  logic                i_tick,
  input  logic [15:0]         i_sample,
  input  logic                q_tick,
  input  logic [15:0]         q_sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_i,
  output logic [15:0]         out_q,
  output logic                overrun,
  output logic                sync_err,
  output logic                running
);

  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned SW = $clog2(SETTLE_PAIRS + 1);
  localparam int unsigned KW = $clog2(SKEW_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t              state;
  logic [DIV_BITS-1:0] div_reg;
  logic [DIV_BITS-1:0] div_cnt;
  logic [FW-1:0]       flush_cnt;
  logic [SW-1:0]       settle_cnt;

  // Pairing latches
  logic                i_have, q_have;
  logic [15:0]         i_lat, q_lat;
  logic [KW-1:0]       skew;

  // Completed pair, consumed the cycle after completion
  logic                pair_v;
  logic [15:0]         pair_i, pair_q;

  // Second buffer entry; the head entry is the out_* registers themselves,
  // which is what gives the two-cycle completion-to-valid latency.
  logic                b1_v;
  logic [15:0]         b1_i, b1_q;

  logic                flow;
  logic                pair_now;
  logic                push, pop;

  always_comb begin
    flow     = 1'b0;
    pair_now = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    // Ticks, pairing and buffering only proceed in SETTLE/RUN while neither
    // a disable nor a rate change is pending; otherwise they are cleared.
    flow     = ((state == ST_SETTLE) || (state == ST_RUN)) && enable &&
               (tick_div == div_reg);
    pair_now = flow && (i_have || i_tick) && (q_have || q_tick);
    push     = flow && pair_v && (state == ST_RUN);
    pop      = out_valid && out_ready;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state       <= ST_IDLE;
      div_reg     <= '0;
      div_cnt     <= '0;
      flush_cnt   <= '0;
      settle_cnt  <= '0;
      i_have      <= 1'b0;
      q_have      <= 1'b0;
      i_lat       <= '0;
      q_lat       <= '0;
      skew        <= '0;
      pair_v      <= 1'b0;
      pair_i      <= '0;
      pair_q      <= '0;
      b1_v        <= 1'b0;
      b1_i        <= '0;
      b1_q        <= '0;
      cic_in_tick <= 1'b0;
      cic_rstb    <= 1'b0;
      out_valid   <= 1'b0;
      out_i       <= '0;
      out_q       <= '0;
      overrun     <= 1'b0;
      sync_err    <= 1'b0;
      running     <= 1'b0;
    end else begin
      cic_in_tick <= 1'b0;
      pair_v      <= 1'b0;

      // ---------------- state machine ----------------
      case (state)
        ST_IDLE: begin
          cic_rstb <= 1'b0;
          running  <= 1'b0;
          if (enable) begin
            state     <= ST_FLUSH;
            div_reg   <= tick_div;
            flush_cnt <= '0;
          end
        end
        ST_FLUSH: begin
          if (!enable) begin
            state    <= ST_IDLE;
            cic_rstb <= 1'b0;
          end else if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
            state      <= ST_SETTLE;
            cic_rstb   <= 1'b1;
            div_cnt    <= '0;
            settle_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        ST_SETTLE, ST_RUN: begin
          if (!enable) begin
            state    <= ST_IDLE;
            cic_rstb <= 1'b0;
            running  <= 1'b0;
          end else if (tick_div != div_reg) begin
            state     <= ST_FLUSH;
            div_reg   <= tick_div;
            flush_cnt <= '0;
            cic_rstb  <= 1'b0;
            running   <= 1'b0;
          end else begin
            if (div_cnt == div_reg) begin
              cic_in_tick <= 1'b1;
              div_cnt     <= '0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
            if ((state == ST_SETTLE) && pair_v) begin
              if (settle_cnt == SW'(SETTLE_PAIRS - 1)) begin
                state   <= ST_RUN;
                running <= 1'b1;
              end else begin
                settle_cnt <= settle_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // ---------------- I/Q pairing ----------------
      if (!flow) begin
        i_have <= 1'b0;
        q_have <= 1'b0;
      end else if (pair_now) begin
        pair_v <= 1'b1;
        pair_i <= i_tick ? i_sample : i_lat;
        pair_q <= q_tick ? q_sample : q_lat;
        i_have <= 1'b0;
        q_have <= 1'b0;
        if ((i_tick && i_have) || (q_tick && q_have))
          sync_err <= 1'b1;
      end else if (i_tick) begin
        // Only one side can be active here; a repeat tick replaces the
        // old sample and restarts the skew window.
        i_lat  <= i_sample;
        i_have <= 1'b1;
        skew   <= KW'(1);
        if (i_have) sync_err <= 1'b1;
      end else if (q_tick) begin
        q_lat  <= q_sample;
        q_have <= 1'b1;
        skew   <= KW'(1);
        if (q_have) sync_err <= 1'b1;
      end else if (i_have || q_have) begin
        if (skew >= KW'(SKEW_MAX)) begin
          i_have   <= 1'b0;
          q_have   <= 1'b0;
          sync_err <= 1'b1;
        end else begin
          skew <= skew + 1'b1;
        end
      end

      // ---------------- 2-entry buffer ----------------
      if (!flow) begin
        out_valid <= 1'b0;
        b1_v      <= 1'b0;
      end else begin
        case ({push, pop})
          2'b01: begin
            out_valid <= b1_v;
            b1_v      <= 1'b0;
            if (b1_v) begin
              out_i <= b1_i;
              out_q <= b1_q;
            end
          end
          2'b10: begin
            if (!out_valid) begin
              out_valid <= 1'b1;
              out_i     <= pair_i;
              out_q     <= pair_q;
            end else if (!b1_v) begin
              b1_v <= 1'b1;
              b1_i <= pair_i;
              b1_q <= pair_q;
            end else begin
              overrun <= 1'b1;
            end
          end
          2'b11: begin
            if (b1_v) begin
              out_i <= b1_i;
              out_q <= b1_q;
              b1_i  <= pair_i;
              b1_q  <= pair_q;
            end else begin
              out_i <= pair_i;
              out_q <= pair_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cic_iq_sequencer.sv
module tb_cic_iq_sequencer;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  tick_div = 8'd3;
  logic        cic_in_tick, cic_rstb;
  logic        i_tick = 1'b0, q_tick = 1'b0;
  logic [15:0] i_sample = '0, q_sample = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] out_i, out_q;
  logic        overrun, sync_err, running;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  cic_iq_sequencer #(
    .FLUSH_CYCLES(4),
    .SETTLE_PAIRS(2),
    .SKEW_MAX    (3),
    .DIV_BITS    (8)
  ) dut (
    .CLK        (CLK),
    .RSTb       (RSTb),
    .enable     (enable),
    .tick_div   (tick_div),
    .cic_in_tick(cic_in_tick),
    .cic_rstb   (cic_rstb),
    .i_tick     (i_tick),
    .i_sample   (i_sample),
    .q_tick     (q_tick),
    .q_sample   (q_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_i      (out_i),
    .out_q      (out_q),
    .overrun    (overrun),
    .sync_err   (sync_err),
    .running    (running)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pair(input logic [15:0] iv, input logic [15:0] qv);
    i_tick = 1'b1; q_tick = 1'b1; i_sample = iv; q_sample = qv;
    step();
    i_tick = 1'b0; q_tick = 1'b0;
  endtask

  task automatic pi(input logic [15:0] v);
    i_tick = 1'b1; i_sample = v;
    step();
    i_tick = 1'b0;
  endtask

  task automatic pq(input logic [15:0] v);
    q_tick = 1'b1; q_sample = v;
    step();
    q_tick = 1'b0;
  endtask

  // Cycles cic_rstb stays low after the FLUSH-entry edge (bounded).
  task automatic flush_len(output int n);
    n = 0;
    step();
    while (!cic_rstb && n < 20) begin
      n++;
      step();
    end
  endtask

  // Distance in cycles between two consecutive cic_in_tick pulses (bounded).
  task automatic period(output int p);
    int w;
    w = 0;
    while (!cic_in_tick && w < 50) begin
      step();
      w++;
    end
    p = 0;
    do begin
      step();
      p++;
    end while (!cic_in_tick && p < 50);
  endtask

  // Enable (or rate change), flush, tick period, and settle discard.
  task automatic start_up(input logic [7:0] div);
    int n, p;
    tick_div = div;
    enable   = 1'b1;
    flush_len(n);
    check("flush_len", n, 4);
    check("settle_not_running", running, 0);
    period(p);
    check("tick_period", p, div + 1);
    pair(16'hAAAA, 16'hBBBB);
    idle(3);
    check("settle_one_discarded", running, 0);
    pair(16'hCCCC, 16'hDDDD);
    idle(3);
    check("run_entered", running, 1);
  endtask

  // Scoreboard monitor: compares every accepted pair with the queue head.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (RSTb && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pair: actual %h_%h required none", out_i, out_q);
        end else begin
          e = exp_q.pop_front();
          check("pair", {out_i, out_q}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    idle(2);
    check("reset_outs",
          {cic_in_tick, cic_rstb, out_valid, overrun, sync_err, running}, 0);
    check("reset_data", {out_i, out_q}, 0);
    RSTb = 1'b1;
    idle(3);
    check("idle_quiet", {cic_rstb, cic_in_tick}, 0);

    // Start-up and first buffered pair with two-cycle latency
    start_up(8'd3);
    exp_q.push_back(32'h0123_FEDC);
    pair(16'h0123, 16'hFEDC);
    check("lat_t1_not_valid", out_valid, 0);
    step();
    check("lat_t2_valid", out_valid, 1);
    idle(3);
    check("drain_first", exp_q.size(), 0);

    // Skew of 3 cycles still pairs
    exp_q.push_back(32'h1111_2222);
    pi(16'h1111);
    idle(2);
    pq(16'h2222);
    idle(4);
    check("skew3_no_err", sync_err, 0);
    check("drain_skew3", exp_q.size(), 0);

    // Overrun: two held in order, third dropped
    out_ready = 1'b0;
    exp_q.push_back(32'hA001_B001);
    exp_q.push_back(32'hA002_B002);
    pair(16'hA001, 16'hB001);
    idle(2);
    pair(16'hA002, 16'hB002);
    idle(2);
    check("full_no_overrun", overrun, 0);
    pair(16'hA003, 16'hB003);
    idle(2);
    check("overrun_set", overrun, 1);
    check("full_head", {out_valid, out_i, out_q}, {1'b1, 32'hA001_B001});
    out_ready = 1'b1;
    idle(4);
    check("drained_invalid", out_valid, 0);
    check("drain_overrun", exp_q.size(), 0);

    // Rate change clears a non-empty buffer and re-flushes
    out_ready = 1'b0;
    pair(16'h0D0D, 16'h0E0E);
    idle(3);
    check("pre_change_valid", out_valid, 1);
    start_up(8'd0);
    check("post_change_empty", out_valid, 0);
    out_ready = 1'b1;
    idle(2);

    // Two I ticks before Q: error, second I sample used
    check("serr_clean", sync_err, 0);
    exp_q.push_back(32'h6666_7777);
    pi(16'h5555);
    idle(1);
    pi(16'h6666);
    idle(1);
    pq(16'h7777);
    idle(4);
    check("double_i_err", sync_err, 1);
    check("drain_double_i", exp_q.size(), 0);

    // Asynchronous reset mid-RUN with a pair held
    out_ready = 1'b0;
    pair(16'h1357, 16'h2468);
    idle(3);
    check("held_valid", out_valid, 1);
    check("overrun_sticky", overrun, 1);
    RSTb = 1'b0;
    #1;
    check("async_reset",
          {cic_in_tick, cic_rstb, out_valid, overrun, sync_err, running}, 0);
    check("async_reset_data", {out_i, out_q}, 0);
    idle(2);
    RSTb = 1'b1;
    out_ready = 1'b1;
    enable = 1'b0;
    idle(2);

    // Skew of 5 cycles: I dropped, nothing emitted
    start_up(8'd3);
    check("serr_after_reset", sync_err, 0);
    pi(16'h3333);
    idle(4);
    pq(16'h4444);
    idle(8);
    check("skew5_err", sync_err, 1);
    check("skew5_no_valid", out_valid, 0);
    exp_q.push_back(32'h0A0A_0B0B);
    pair(16'h0A0A, 16'h0B0B);
    idle(4);
    check("drain_after_skew", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
